ch_buf_gen: RTL and testbench

//  Parametrised per-channel DMA buffer between the Wishbone slave data path (ss_*) and an engine module (m_*).

---
 rtl/ch_buf_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_ch_buf_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_buf_gen.sv
// Per-channel DMA buffer: a source FIFO (bus -> engine) and a destination FIFO (engine -> bus),
// each holding DW data bits plus a last tag, with a descriptor word counter and sticky error flags.

module ch_buf_fifo #(
  parameter int W      = 65,
  parameter int AW     = 9,
  parameter int AF_THR = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          afull_o
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_L    = (AW+1)'(DEPTH - AF_THR);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  // A clear drops any same-cycle push or pop.
  assign push_ok = push_i & ~full_o & ~clr_i;
  assign pop_ok  = pop_i & ~empty_o & ~clr_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign level_o = level_q;
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DEPTH_L);
  assign afull_o = (level_q >= AF_L);
  // Show-ahead head; forced to zero while empty so outputs are clean out of reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

module ch_buf_gen #(
  parameter int DW        = 64,
  parameter int AW        = 9,
  parameter int AE_THR    = 2,
  parameter int AF_THR    = 4,
  parameter int START_THR = 2**(AW-1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          m_reset0,
  input  logic [23:0]   dc0,
  input  logic          ss_xfer0,
  input  logic          ss_last0,
  input  logic [DW-1:0] wbs_dat_o0,
  output logic          ss_stop0,
  output logic          ss_start0,
  output logic          ss_end0,
  input  logic          ss_xfer1,
  output logic [DW-1:0] wbs_dat_i1,
  output logic          ss_stop1,
  output logic          ss_start1,
  output logic          ss_end1,
  input  logic          m_src_getn0,
  output logic [DW-1:0] m_src0,
  output logic          m_src_last0,
  output logic          m_src_empty0,
  output logic          m_src_almost_empty0,
  input  logic          m_dst_putn0,
  input  logic [DW-1:0] m_dst0,
  input  logic          m_dst_last0,
  output logic          m_dst_full0,
  output logic          m_dst_almost_full0,
  input  logic          m_endn0,
  output logic [AW:0]   src_level,
  output logic [AW:0]   dst_level,
  output logic [3:0]    err_o
);

  localparam logic [AW:0] AE_L    = (AW+1)'(AE_THR);
  localparam logic [AW:0] START_L = (AW+1)'(START_THR);

  logic [DW:0] src_din, src_dout, dst_din, dst_dout;
  logic        src_empty, src_full, src_afull;
  logic        dst_empty, dst_full, dst_afull;
  logic        src_push, src_acc, src_tag;
  logic        dst_head_last, dst_pop_acc;
  logic [3:0]  err_ev;

  logic [23:0] rem_q, rem_d;
  logic        dc_nz_q, dc_nz_d;
  logic        end_seen_q, end_seen_d;
  logic [3:0]  err_q, err_d;

  // Once the descriptor is exhausted the source side refuses further words.
  assign ss_end0  = dc_nz_q & (rem_q == '0);
  assign src_push = ss_xfer0 & ~ss_end0;
  assign src_acc  = src_push & ~src_full & ~m_reset0;
  assign src_tag  = ss_last0 | (dc_nz_q & (rem_q == 24'd1));
  assign src_din  = {src_tag, wbs_dat_o0};
  assign dst_din  = {m_dst_last0, m_dst0};

  ch_buf_fifo #(.W(DW+1), .AW(AW), .AF_THR(AF_THR)) u_src (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (m_reset0),
    .push_i  (src_push),
    .pop_i   (~m_src_getn0),
    .din_i   (src_din),
    .dout_o  (src_dout),
    .level_o (src_level),
    .empty_o (src_empty),
    .full_o  (src_full),
    .afull_o (src_afull)
  );

  ch_buf_fifo #(.W(DW+1), .AW(AW), .AF_THR(AF_THR)) u_dst (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (m_reset0),
    .push_i  (~m_dst_putn0),
    .pop_i   (ss_xfer1),
    .din_i   (dst_din),
    .dout_o  (dst_dout),
    .level_o (dst_level),
    .empty_o (dst_empty),
    .full_o  (dst_full),
    .afull_o (dst_afull)
  );

  assign dst_head_last = dst_dout[DW];
  assign dst_pop_acc   = ss_xfer1 & ~dst_empty & ~m_reset0;

  // Bit order matches err_o: {dst_unf, dst_ovf, src_unf, src_ovf}.
  assign err_ev = {ss_xfer1 & dst_empty,
                   ~m_dst_putn0 & dst_full,
                   ~m_src_getn0 & src_empty,
                   ss_xfer0 & (src_full | ss_end0)};

  always_comb begin
    rem_d      = rem_q;
    dc_nz_d    = dc_nz_q;
    end_seen_d = end_seen_q;
    err_d      = err_q;
    if (m_reset0) begin
      rem_d      = dc0;
      dc_nz_d    = (dc0 != '0);
      end_seen_d = 1'b0;
      err_d      = '0;
    end else begin
      if (dc_nz_q && src_acc) rem_d = rem_q - 24'd1;
      if (!m_endn0)                          end_seen_d = 1'b1;
      else if (dst_pop_acc && dst_head_last) end_seen_d = 1'b0;
      err_d = err_q | err_ev;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rem_q      <= '0;
      dc_nz_q    <= 1'b0;
      end_seen_q <= 1'b0;
      err_q      <= '0;
    end else begin
      rem_q      <= rem_d;
      dc_nz_q    <= dc_nz_d;
      end_seen_q <= end_seen_d;
      err_q      <= err_d;
    end
  end

  assign m_src0              = src_dout[DW-1:0];
  assign m_src_last0         = src_dout[DW];
  assign m_src_empty0        = src_empty;
  assign m_src_almost_empty0 = (src_level <= AE_L);
  assign m_dst_full0         = dst_full;
  assign m_dst_almost_full0  = dst_afull;
  assign wbs_dat_i1          = dst_dout[DW-1:0];

  assign ss_stop0  = src_afull | ss_end0;
  assign ss_start0 = (src_level < START_L) & ~ss_end0;
  assign ss_stop1  = dst_afull;
  assign ss_start1 = (dst_level >= START_L) | (end_seen_q & ~dst_empty);
  assign ss_end1   = ~dst_empty & dst_head_last;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ch_buf_gen.sv
// Directed bench for ch_buf_gen with DW=64, AW=4 (16-entry FIFOs, start watermark 8).

module tb_ch_buf_gen;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        m_reset0, ss_xfer0, ss_last0, ss_xfer1;
  logic        m_src_getn0, m_dst_putn0, m_dst_last0, m_endn0;
  logic [23:0] dc0;
  logic [63:0] wbs_dat_o0, m_dst0;
  logic [63:0] wbs_dat_i1, m_src0;
  logic        ss_stop0, ss_start0, ss_end0, ss_stop1, ss_start1, ss_end1;
  logic        m_src_last0, m_src_empty0, m_src_almost_empty0;
  logic        m_dst_full0, m_dst_almost_full0;
  logic [4:0]  src_level, dst_level;
  logic [3:0]  err_o;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  ch_buf_gen #(.DW(64), .AW(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .m_reset0(m_reset0), .dc0(dc0),
    .ss_xfer0(ss_xfer0), .ss_last0(ss_last0), .wbs_dat_o0(wbs_dat_o0),
    .ss_stop0(ss_stop0), .ss_start0(ss_start0), .ss_end0(ss_end0),
    .ss_xfer1(ss_xfer1), .wbs_dat_i1(wbs_dat_i1),
    .ss_stop1(ss_stop1), .ss_start1(ss_start1), .ss_end1(ss_end1),
    .m_src_getn0(m_src_getn0), .m_src0(m_src0), .m_src_last0(m_src_last0),
    .m_src_empty0(m_src_empty0), .m_src_almost_empty0(m_src_almost_empty0),
    .m_dst_putn0(m_dst_putn0), .m_dst0(m_dst0), .m_dst_last0(m_dst_last0),
    .m_dst_full0(m_dst_full0), .m_dst_almost_full0(m_dst_almost_full0),
    .m_endn0(m_endn0), .src_level(src_level), .dst_level(dst_level), .err_o(err_o)
  );

  typedef struct {
    logic        rst;
    logic        x0;
    logic        l0;
    logic [63:0] d0;
    logic        x1;
    logic        getn;
    logic        putn;
    logic [63:0] dd;
    logic        dl;
    logic [4:0]  e_sl;
    logic [4:0]  e_dl;
    logic [3:0]  e_err;
    logic [63:0] e_sh;
    logic        e_slast;
    logic [63:0] e_dh;
    logic        e_end1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle();
    m_reset0 = 1'b0; ss_xfer0 = 1'b0; ss_last0 = 1'b0; ss_xfer1 = 1'b0;
    m_src_getn0 = 1'b1; m_dst_putn0 = 1'b1; m_dst_last0 = 1'b0; m_endn0 = 1'b1;
    wbs_dat_o0 = '0; m_dst0 = '0;
  endtask

  task automatic clear(input logic [23:0] dc);
    idle();
    dc0 = dc;
    m_reset0 = 1'b1;
    step();
    m_reset0 = 1'b0;
    $display("clear dc0=%0d src_level=%0d dst_level=%0d err=%b", dc, src_level, dst_level, err_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rst,x0,l0,d0,x1,getn,putn,dd,dl, e_sl,e_dl,e_err,e_sh,e_slast,e_dh,e_end1}
    tbl[0] = '{1'b0,1'b0,1'b0,64'h0 ,1'b1,1'b1,1'b0,64'hAA,1'b0, 5'd0,5'd1,4'b1000,64'h0 ,1'b0,64'hAA,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b0,64'h0 ,1'b0,1'b1,1'b1,64'h0 ,1'b0, 5'd0,5'd1,4'b1000,64'h0 ,1'b0,64'hAA,1'b0};
    tbl[2] = '{1'b0,1'b0,1'b0,64'h0 ,1'b1,1'b1,1'b0,64'hBB,1'b1, 5'd0,5'd1,4'b1000,64'h0 ,1'b0,64'hBB,1'b1};
    tbl[3] = '{1'b0,1'b0,1'b0,64'h0 ,1'b1,1'b1,1'b1,64'h0 ,1'b0, 5'd0,5'd0,4'b1000,64'h0 ,1'b0,64'h0 ,1'b0};
    tbl[4] = '{1'b0,1'b1,1'b1,64'h11,1'b0,1'b1,1'b1,64'h0 ,1'b0, 5'd1,5'd0,4'b1000,64'h11,1'b1,64'h0 ,1'b0};
    tbl[5] = '{1'b0,1'b1,1'b0,64'h22,1'b0,1'b0,1'b1,64'h0 ,1'b0, 5'd1,5'd0,4'b1000,64'h22,1'b0,64'h0 ,1'b0};
    tbl[6] = '{1'b0,1'b0,1'b0,64'h0 ,1'b0,1'b0,1'b1,64'h0 ,1'b0, 5'd0,5'd0,4'b1000,64'h0 ,1'b0,64'h0 ,1'b0};
    tbl[7] = '{1'b0,1'b0,1'b0,64'h0 ,1'b0,1'b0,1'b1,64'h0 ,1'b0, 5'd0,5'd0,4'b1010,64'h0 ,1'b0,64'h0 ,1'b0};
    tbl[8] = '{1'b1,1'b1,1'b0,64'h33,1'b0,1'b1,1'b1,64'h0 ,1'b0, 5'd0,5'd0,4'b0000,64'h0 ,1'b0,64'h0 ,1'b0};

    idle();
    dc0 = '0;
    #1 wb_rst_ni = 1'b0;
    #12;
    $display("reset src_level=%0d dst_level=%0d err=%b", src_level, dst_level, err_o);
    chk("rst_src_level", 64'(src_level), 64'd0);
    chk("rst_dst_level", 64'(dst_level), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_flags", {54'd0, m_src_empty0, m_src_almost_empty0, m_dst_full0, m_dst_almost_full0,
                      ss_stop0, ss_start0, ss_end0, ss_stop1, ss_start1, ss_end1},
        64'b11_0001_0000);
    chk("rst_src_head", m_src0, 64'd0);
    chk("rst_src_last", 64'(m_src_last0), 64'd0);
    chk("rst_dst_head", wbs_dat_i1, 64'd0);
    @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    step();

    // Fill the source FIFO past capacity, then drain it in order.
    for (int i = 0; i < 17; i++) begin
      ss_xfer0 = 1'b1;
      wbs_dat_o0 = 64'(i);
      step();
      $display("src push %0d level=%0d stop0=%b err=%b", i, src_level, ss_stop0, err_o);
      chk("t1_level", 64'(src_level), 64'((i < 16) ? i + 1 : 16));
      chk("t1_stop0", 64'(ss_stop0), 64'((i + 1) >= 12));
      if (i == 15) chk("t1_err_at_full", 64'(err_o), 64'd0);
    end
    chk("t1_ovf", 64'(err_o), 64'b0001);
    idle();
    for (int j = 0; j < 16; j++) begin
      chk("t1_head", m_src0, 64'(j));
      chk("t1_aempty", 64'(m_src_almost_empty0), 64'((16 - j) <= 2));
      m_src_getn0 = 1'b0;
      step();
      $display("src pop %0d level=%0d", j, src_level);
    end
    chk("t1_empty", 64'(m_src_empty0), 64'd1);
    step();
    chk("t1_unf", 64'(err_o), 64'b0011);
    m_src_getn0 = 1'b1;

    // Steady push+pop at level 8 across the pointer wrap.
    clear(24'd0);
    chk("t2_clr_err", 64'(err_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      ss_xfer0 = 1'b1;
      wbs_dat_o0 = 64'(100 + i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      chk("t2_head", m_src0, 64'(100 + k));
      ss_xfer0 = 1'b1;
      wbs_dat_o0 = 64'(108 + k);
      m_src_getn0 = 1'b0;
      step();
      $display("src push+pop %0d level=%0d head=%0d", k, src_level, m_src0);
      chk("t2_level", 64'(src_level), 64'd8);
    end
    idle();
    for (int j = 0; j < 8; j++) begin
      chk("t2_tail", m_src0, 64'(120 + j));
      m_src_getn0 = 1'b0;
      step();
    end
    idle();
    chk("t2_err", 64'(err_o), 64'd0);
    chk("t2_level0", 64'(src_level), 64'd0);

    // Descriptor count 5: fifth word auto-tagged, later words refused.
    clear(24'd5);
    chk("t3_end0_init", 64'(ss_end0), 64'd0);
    for (int i = 0; i < 7; i++) begin
      ss_xfer0 = 1'b1;
      ss_last0 = 1'b0;
      wbs_dat_o0 = 64'(200 + i);
      step();
      $display("dc push %0d level=%0d end0=%b stop0=%b err=%b", i, src_level, ss_end0, ss_stop0, err_o);
      chk("t3_end0", 64'(ss_end0), 64'(i >= 4));
      chk("t3_stop0", 64'(ss_stop0), 64'(i >= 4));
      chk("t3_level", 64'(src_level), 64'((i < 5) ? i + 1 : 5));
      chk("t3_ovf", 64'(err_o[0]), 64'(i >= 5));
    end
    idle();
    chk("t3_start0", 64'(ss_start0), 64'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_head", m_src0, 64'(200 + k));
      chk("t3_last", 64'(m_src_last0), 64'(k == 4));
      m_src_getn0 = 1'b0;
      step();
    end
    idle();

    // Engine finishes early: end_seen raises ss_start1 below the watermark.
    clear(24'd0);
    for (int i = 0; i < 3; i++) begin
      m_dst_putn0 = 1'b0;
      m_dst0 = 64'(300 + i);
      m_dst_last0 = (i == 2);
      step();
    end
    idle();
    chk("t4_level", 64'(dst_level), 64'd3);
    chk("t4_start1_pre", 64'(ss_start1), 64'd0);
    chk("t4_end1_pre", 64'(ss_end1), 64'd0);
    m_endn0 = 1'b0;
    step();
    m_endn0 = 1'b1;
    $display("endn pulse dst_level=%0d start1=%b", dst_level, ss_start1);
    chk("t4_start1", 64'(ss_start1), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_head", wbs_dat_i1, 64'(300 + k));
      chk("t4_end1", 64'(ss_end1), 64'(k == 2));
      ss_xfer1 = 1'b1;
      step();
      $display("dst pop %0d level=%0d", k, dst_level);
    end
    idle();
    m_dst_putn0 = 1'b0;
    m_dst0 = 64'd400;
    step();
    idle();
    chk("t4_endseen_clr", 64'(ss_start1), 64'd0);
    chk("t4_level1", 64'(dst_level), 64'd1);

    // Single-cycle vectors: underflow with same-cycle push, show-ahead, clear priority.
    clear(24'd0);
    for (int v = 0; v < 9; v++) begin
      m_reset0 = tbl[v].rst; ss_xfer0 = tbl[v].x0; ss_last0 = tbl[v].l0; wbs_dat_o0 = tbl[v].d0;
      ss_xfer1 = tbl[v].x1; m_src_getn0 = tbl[v].getn; m_dst_putn0 = tbl[v].putn;
      m_dst0 = tbl[v].dd; m_dst_last0 = tbl[v].dl;
      step();
      $display("vec %0d src_level=%0d dst_level=%0d err=%b src_head=0x%0h dst_head=0x%0h",
               v, src_level, dst_level, err_o, m_src0, wbs_dat_i1);
      chk("tv_src_level", 64'(src_level), 64'(tbl[v].e_sl));
      chk("tv_dst_level", 64'(dst_level), 64'(tbl[v].e_dl));
      chk("tv_err", 64'(err_o), 64'(tbl[v].e_err));
      chk("tv_src_head", m_src0, tbl[v].e_sh);
      chk("tv_src_last", 64'(m_src_last0), 64'(tbl[v].e_slast));
      chk("tv_dst_head", wbs_dat_i1, tbl[v].e_dh);
      chk("tv_end1", 64'(ss_end1), 64'(tbl[v].e_end1));
    end
    idle();

    // Synchronous clear in the middle of traffic.
    ss_xfer1 = 1'b1;
    step();
    chk("t6_unf", 64'(err_o), 64'b1000);
    idle();
    for (int i = 0; i < 6; i++) begin
      ss_xfer0 = 1'b1; wbs_dat_o0 = 64'(500 + i);
      m_dst_putn0 = 1'b0; m_dst0 = 64'(600 + i);
      step();
    end
    chk("t6_src6", 64'(src_level), 64'd6);
    chk("t6_dst6", 64'(dst_level), 64'd6);
    ss_xfer0 = 1'b1; m_src_getn0 = 1'b0; m_dst_putn0 = 1'b0; ss_xfer1 = 1'b1;
    m_reset0 = 1'b1;
    step();
    idle();
    $display("sync clear src_level=%0d dst_level=%0d err=%b", src_level, dst_level, err_o);
    chk("t6_src_level", 64'(src_level), 64'd0);
    chk("t6_dst_level", 64'(dst_level), 64'd0);
    chk("t6_err", 64'(err_o), 64'd0);
    chk("t6_empties", {62'd0, m_src_empty0, m_src_almost_empty0}, 64'b11);
    chk("t6_start0", 64'(ss_start0), 64'd1);

    // Asynchronous reset in the middle of a burst.
    clear(24'd3);
    for (int i = 0; i < 4; i++) begin
      ss_xfer0 = 1'b1;
      wbs_dat_o0 = 64'(700 + i);
      step();
    end
    chk("t6_end0", 64'(ss_end0), 64'd1);
    chk("t6_ovf", 64'(err_o), 64'b0001);
    wb_rst_ni = 1'b0;
    #1;
    $display("async reset src_level=%0d err=%b end0=%b", src_level, err_o, ss_end0);
    chk("t6_ar_level", 64'(src_level), 64'd0);
    chk("t6_ar_err", 64'(err_o), 64'd0);
    chk("t6_ar_end0", 64'(ss_end0), 64'd0);
    chk("t6_ar_start0", 64'(ss_start0), 64'd1);
    chk("t6_ar_empty", 64'(m_src_empty0), 64'd1);
    chk("t6_ar_head", m_src0, 64'd0);
    step();
    chk("t6_ar_hold", 64'(src_level), 64'd0);
    idle();
    wb_rst_ni = 1'b1;
    step();
    chk("t6_ar_after", 64'(src_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
